// File: rtl/mem_pkg.sv
// Shared types for the posted-write buffer: address/data words, buffer entry
// layout and the controller state encoding.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  typedef struct packed {
    mem_addr_t addr;
    mem_word_t data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular queue of posted writes with an associative lookup that returns the
// youngest queued entry whose address matches the lookup address.
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [ADDR_W-1:0]          i_push_addr,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [ADDR_W-1:0]          o_head_addr,
  output logic [DATA_W-1:0]          o_head_data,
  input  logic [ADDR_W-1:0]          i_lookup_addr,
  output logic                       o_hit,
  output logic [DATA_W-1:0]          o_hit_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   w_idx;

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= '{addr: i_push_addr, data: i_push_data};
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest over live entries so the last match wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[w_idx].data;
      end
    end
  end

  assign o_head_addr = r_mem[r_rptr].addr;
  assign o_head_data = r_mem[r_rptr].data;
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the CPU port and memory. Writes are queued and
// drained in order; reads forward from the queue on a hit and otherwise go to
// memory ahead of pending drains.
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_writeEnable,
  input  logic [ADDR_W-1:0]          cpu_address,
  input  logic [DATA_W-1:0]          cpu_dataToMemory,
  output logic                       cpu_ready,
  output logic                       cpu_rvalid,
  output logic [DATA_W-1:0]          cpu_dataFromMemory,
  output logic                       mem_req,
  output logic                       mem_writeEnable,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_dataToMemory,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_dataFromMemory,
  output logic                       buf_full,
  output logic                       buf_empty,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  wbuf_state_e       r_state;
  wbuf_state_e       w_state_next;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_raddr;

  logic              w_push;
  logic              w_pop;
  logic              w_load_hit;
  logic              w_load_mem;
  logic              w_capture;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_full;
  logic              w_empty;

  wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk           (clk),
    .i_rst_n       (reset),
    .i_push        (w_push),
    .i_push_addr   (cpu_address),
    .i_push_data   (cpu_dataToMemory),
    .i_pop         (w_pop),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .i_lookup_addr (cpu_address),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (buf_count)
  );

  // Controller state register; reset abandons any outstanding memory access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, CPU handshake, queue push/pop and memory port drive.
  always_comb begin
    w_state_next     = r_state;
    cpu_ready        = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_load_hit       = 1'b0;
    w_load_mem       = 1'b0;
    w_capture        = 1'b0;
    mem_req          = 1'b0;
    mem_writeEnable  = 1'b0;
    mem_address      = '0;
    mem_dataToMemory = '0;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_writeEnable) begin
            cpu_ready = !w_full;
            w_push    = !w_full;
          end else begin
            cpu_ready = 1'b1;
            if (w_hit) w_load_hit = 1'b1;
            else       w_capture  = 1'b1;
          end
        end
        // A read miss takes the memory port before queued writes.
        if (w_capture)     w_state_next = READ;
        else if (!w_empty) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (cpu_req && cpu_writeEnable && !w_full) begin
          cpu_ready = 1'b1;
          w_push    = 1'b1;
        end
        mem_req          = 1'b1;
        mem_writeEnable  = 1'b1;
        mem_address      = w_head_addr;
        mem_dataToMemory = w_head_data;
        if (mem_ack) begin
          w_pop        = 1'b1;
          w_state_next = IDLE;
        end
      end
      READ: begin
        mem_req     = 1'b1;
        mem_address = r_raddr;
        if (mem_ack) begin
          w_load_mem   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read-valid pulse follows a forwarded hit or a completed memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rvalid <= 1'b0;
    else        r_rvalid <= w_load_hit | w_load_mem;
  end

  // Miss address and returned read data are only meaningful with their qualifiers.
  always_ff @(posedge clk) begin
    if (w_capture)       r_raddr <= cpu_address;
    if (w_load_hit)      r_rdata <= w_hit_data;
    else if (w_load_mem) r_rdata <= mem_dataFromMemory;
  end

  assign cpu_rvalid         = r_rvalid;
  assign cpu_dataFromMemory = r_rdata;
  assign buf_full           = w_full;
  assign buf_empty          = w_empty;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: a cycle table for the main queue,
// forwarding and drain behaviour, plus sequences for drain ordering, read miss
// latency and reset during a drain.
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_writeEnable = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [15:0] cpu_dataToMemory = '0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_dataFromMemory;
  logic        mem_req;
  logic        mem_writeEnable;
  logic [15:0] mem_address;
  logic [15:0] mem_dataToMemory;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dataFromMemory = '0;
  logic        buf_full;
  logic        buf_empty;
  logic [2:0]  buf_count;

  int checks = 0;
  int errors = 0;

  mem_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_req            (cpu_req),
    .cpu_writeEnable    (cpu_writeEnable),
    .cpu_address        (cpu_address),
    .cpu_dataToMemory   (cpu_dataToMemory),
    .cpu_ready          (cpu_ready),
    .cpu_rvalid         (cpu_rvalid),
    .cpu_dataFromMemory (cpu_dataFromMemory),
    .mem_req            (mem_req),
    .mem_writeEnable    (mem_writeEnable),
    .mem_address        (mem_address),
    .mem_dataToMemory   (mem_dataToMemory),
    .mem_ack            (mem_ack),
    .mem_dataFromMemory (mem_dataFromMemory),
    .buf_full           (buf_full),
    .buf_empty          (buf_empty),
    .buf_count          (buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] ackdata;
    logic        e_ready;
    logic        e_rvalid;
    logic [15:0] e_rdata;
    logic        e_mreq;
    logic        e_mwe;
    logic [15:0] e_maddr;
    logic [15:0] e_mdata;
    int          e_count;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic req, logic we, logic [15:0] addr,
                              logic [15:0] wdata, logic ack, logic [15:0] ackdata,
                              logic e_ready, logic e_rvalid, logic [15:0] e_rdata,
                              logic e_mreq, logic e_mwe, logic [15:0] e_maddr,
                              logic [15:0] e_mdata, int e_count);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.ackdata = ackdata; v.e_ready = e_ready; v.e_rvalid = e_rvalid;
    v.e_rdata = e_rdata; v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr;
    v.e_mdata = e_mdata; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Occupancy flags must stay mutually consistent every cycle.
  always @(negedge clk) begin
    checks++;
    if ((buf_full && buf_empty) || (buf_full !== (buf_count == 3'd4)) ||
        (buf_empty !== (buf_count == 3'd0))) begin
      errors++;
      $display("FAIL flags full=%0b empty=%0b count=%0d", buf_full, buf_empty, buf_count);
    end
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_writeEnable = 1'b0; cpu_address = '0;
    cpu_dataToMemory = '0; mem_ack = 1'b0; mem_dataFromMemory = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    reset = 1'b1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] data);
    cpu_req = req; cpu_writeEnable = we; cpu_address = addr; cpu_dataToMemory = data;
  endtask

  initial begin
    // rst req we addr wdata ack ackdata | ready rvalid rdata mreq mwe maddr mdata count
    vecs[0]  = mk(1, 1, 1, 16'h10, 16'hA0, 0, 0,          1, 0, 0,        0, 0, 0,     0,        0);
    vecs[1]  = mk(0, 1, 1, 16'h11, 16'hA1, 0, 0,          1, 0, 0,        0, 0, 0,     0,        1);
    vecs[2]  = mk(0, 1, 1, 16'h12, 16'hA2, 0, 0,          1, 0, 0,        1, 1, 16'h10, 16'hA0,  2);
    vecs[3]  = mk(0, 1, 1, 16'h13, 16'hA3, 0, 0,          1, 0, 0,        1, 1, 16'h10, 16'hA0,  3);
    vecs[4]  = mk(0, 1, 1, 16'h14, 16'hA4, 0, 0,          0, 0, 0,        1, 1, 16'h10, 16'hA0,  4);
    vecs[5]  = mk(0, 0, 0, 0,      0,      0, 0,          0, 0, 0,        1, 1, 16'h10, 16'hA0,  4);
    vecs[6]  = mk(0, 1, 1, 16'h14, 16'hA4, 1, 0,          0, 0, 0,        1, 1, 16'h10, 16'hA0,  4);
    vecs[7]  = mk(0, 1, 1, 16'h15, 16'hA5, 0, 0,          1, 0, 0,        0, 0, 0,     0,        3);
    vecs[8]  = mk(0, 0, 0, 0,      0,      1, 0,          0, 0, 0,        1, 1, 16'h11, 16'hA1,  4);
    vecs[9]  = mk(0, 0, 0, 0,      0,      0, 0,          0, 0, 0,        0, 0, 0,     0,        3);
    vecs[10] = mk(0, 1, 1, 16'h16, 16'hA6, 1, 0,          1, 0, 0,        1, 1, 16'h12, 16'hA2,  3);
    vecs[11] = mk(0, 0, 0, 0,      0,      0, 0,          0, 0, 0,        0, 0, 0,     0,        3);
    vecs[12] = mk(0, 0, 0, 0,      0,      1, 0,          0, 0, 0,        1, 1, 16'h13, 16'hA3,  3);
    vecs[13] = mk(0, 1, 0, 16'h14, 0,      0, 0,          1, 0, 0,        0, 0, 0,     0,        2);
    vecs[14] = mk(0, 1, 1, 16'h77, 16'h7777, 1, 16'h5A5A, 0, 0, 0,        1, 0, 16'h14, 0,       2);
    vecs[15] = mk(0, 0, 0, 0,      0,      0, 0,          0, 1, 16'h5A5A, 0, 0, 0,     0,        2);
    vecs[16] = mk(0, 1, 0, 16'h15, 0,      0, 0,          0, 0, 0,        1, 1, 16'h15, 16'hA5,  2);
    vecs[17] = mk(0, 0, 0, 0,      0,      1, 0,          0, 0, 0,        1, 1, 16'h15, 16'hA5,  2);
    vecs[18] = mk(0, 1, 0, 16'h15, 0,      0, 0,          1, 0, 0,        0, 0, 0,     0,        1);
    vecs[19] = mk(0, 1, 0, 16'h15, 0,      1, 16'h0BAD,   0, 0, 0,        1, 0, 16'h15, 0,       1);
    vecs[20] = mk(0, 1, 0, 16'h16, 0,      0, 0,          1, 1, 16'h0BAD, 0, 0, 0,     0,        1);
    vecs[21] = mk(0, 0, 0, 0,      0,      1, 0,          0, 1, 16'hA6,   1, 1, 16'h16, 16'hA6,  1);
    vecs[22] = mk(0, 0, 0, 0,      0,      0, 0,          0, 0, 0,        0, 0, 0,     0,        0);
    vecs[23] = mk(1, 1, 1, 16'h20, 16'h1111, 0, 0,        1, 0, 0,        0, 0, 0,     0,        0);
    vecs[24] = mk(0, 1, 1, 16'h20, 16'h2222, 0, 0,        1, 0, 0,        0, 0, 0,     0,        1);
    vecs[25] = mk(0, 1, 1, 16'h20, 16'h3333, 0, 0,        1, 0, 0,        1, 1, 16'h20, 16'h1111, 2);
    vecs[26] = mk(0, 1, 0, 16'h20, 0,      1, 0,          0, 0, 0,        1, 1, 16'h20, 16'h1111, 3);
    vecs[27] = mk(0, 1, 0, 16'h20, 0,      0, 0,          1, 0, 0,        0, 0, 0,     0,        2);
    vecs[28] = mk(0, 0, 0, 0,      0,      0, 0,          0, 1, 16'h3333, 1, 1, 16'h20, 16'h2222, 2);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      cpu_drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      mem_ack = vecs[i].ack;
      mem_dataFromMemory = vecs[i].ackdata;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_rvalid)
        chk($sformatf("v%0d_rdata", i), 32'(cpu_dataFromMemory), 32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_writeEnable), 32'(vecs[i].e_mwe));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_address), 32'(vecs[i].e_maddr));
      chk($sformatf("v%0d_mem_data", i), 32'(mem_dataToMemory), 32'(vecs[i].e_mdata));
      chk($sformatf("v%0d_count", i), 32'(buf_count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_full", i), 32'(buf_full), 32'(vecs[i].e_count == 4));
      chk($sformatf("v%0d_empty", i), 32'(buf_empty), 32'(vecs[i].e_count == 0));
    end

    // Drain order: three queued writes, each acked on the third cycle of its request.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cpu_drive(1'b1, 1'b1, 16'h30 + 16'(k), 16'hC0 + 16'(k));
      #1;
      chk($sformatf("drain_wr%0d_ready", k), 32'(cpu_ready), 32'd1);
    end
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      #1;
      while (!mem_req && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk($sformatf("drain%0d_req", k), 32'(mem_req), 32'd1);
      chk($sformatf("drain%0d_we", k), 32'(mem_writeEnable), 32'd1);
      chk($sformatf("drain%0d_addr", k), 32'(mem_address), 32'h30 + 32'(k));
      chk($sformatf("drain%0d_data", k), 32'(mem_dataToMemory), 32'hC0 + 32'(k));
      @(negedge clk);
      #1;
      chk($sformatf("drain%0d_hold", k), 32'(mem_address), 32'h30 + 32'(k));
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk($sformatf("drain%0d_ackaddr", k), 32'(mem_address), 32'h30 + 32'(k));
      @(negedge clk);
      mem_ack = 1'b0;
    end
    #1;
    chk("drain_end_empty", 32'(buf_empty), 32'd1);
    chk("drain_end_count", 32'(buf_count), 32'd0);
    chk("drain_end_req", 32'(mem_req), 32'd0);

    // Read miss with a three-cycle memory latency.
    do_reset();
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 16'h40, 16'h0);
    #1;
    chk("miss_ready", 32'(cpu_ready), 32'd1);
    chk("miss_req_early", 32'(mem_req), 32'd0);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 16'h41, 16'h1234);
    #1;
    chk("miss_wr_blocked", 32'(cpu_ready), 32'd0);
    chk("miss_req", 32'(mem_req), 32'd1);
    chk("miss_we", 32'(mem_writeEnable), 32'd0);
    chk("miss_addr", 32'(mem_address), 32'h40);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 16'h40, 16'h0);
    #1;
    chk("miss_rd_blocked", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    mem_ack = 1'b1;
    mem_dataFromMemory = 16'hBEEF;
    #1;
    chk("miss_req_held", 32'(mem_req), 32'd1);
    chk("miss_no_early_rvalid", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_dataFromMemory = '0;
    #1;
    chk("miss_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("miss_rdata", 32'(cpu_dataFromMemory), 32'hBEEF);
    chk("miss_req_done", 32'(mem_req), 32'd0);
    chk("miss_count", 32'(buf_count), 32'd0);
    @(negedge clk);
    #1;
    chk("miss_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 16'h50, 16'h5555);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 16'h51, 16'h5151);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    chk("rstmid_count_before", 32'(buf_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_req", 32'(mem_req), 32'd0);
    chk("rstmid_count", 32'(buf_count), 32'd0);
    chk("rstmid_empty", 32'(buf_empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_after_req", 32'(mem_req), 32'd0);
    chk("rstmid_after_count", 32'(buf_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
